// File: rtl/fft_bf_if.sv
// Scheduler-to-datapath bundle for the radix-2 DIT FFT butterfly scheduler.
// The master side is the control/datapath (start, stall, bf_valid). The slave side is the scheduler.
interface fft_bf_if #(
  parameter int unsigned N_LOG2 = 10
);
  localparam int unsigned STG_W = $clog2(N_LOG2);

  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic [STG_W-1:0]  stage;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr;
  logic              rd_first;
  logic              tw_en;
  logic [N_LOG2-2:0] tw_addr;
  logic              bf_valid;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;
  logic              err;

  modport master (
    output start, stall, bf_valid,
    input  busy, done, stage, rd_en, rd_addr, rd_first, tw_en, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, err
  );

  modport slave (
    input  start, stall, bf_valid,
    output busy, done, stage, rd_en, rd_addr, rd_first, tw_en, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, err
  );
endinterface

// File: rtl/fft_bf_scheduler.sv
// In-place radix-2 DIT FFT sequencer. It walks every stage and butterfly and
// issues an (a, b) read pair plus a twiddle index for each butterfly. An
// in-flight address FIFO supplies the write-back addresses.
// Each stage boundary is held until the FIFO drains, which avoids read-after-write hazards.
// Optional checker: define FFT_SCHED_ERRCHK_EN to get a sticky err flag.
module fft_bf_scheduler #(
  parameter int unsigned N_LOG2        = 10,
  parameter int unsigned AF_DEPTH_LOG2 = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  fft_bf_if.slave bus
);

  localparam int unsigned STG_W = $clog2(N_LOG2);
  localparam int unsigned SW    = STG_W + 1;
  localparam int unsigned K_W   = N_LOG2 - 1;
  localparam int unsigned AF_D  = 1 << AF_DEPTH_LOG2;
  localparam int unsigned CNT_W = AF_DEPTH_LOG2 + 1;
  localparam logic [K_W-1:0]   K_LAST = '1;
  localparam logic [STG_W-1:0] S_LAST = STG_W'(N_LOG2 - 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, DRAIN, FIN} state_t;

  state_t              r_state;
  logic [STG_W-1:0]    r_stage;
  logic [K_W-1:0]      r_k;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_en;
  logic                r_rd_first;
  logic [N_LOG2-1:0]   r_rd_addr;
  logic                r_tw_en;
  logic [K_W-1:0]      r_tw_addr;

  logic [N_LOG2-1:0]        r_fa [AF_D];
  logic [N_LOG2-1:0]        r_fb [AF_D];
  logic [AF_DEPTH_LOG2-1:0] r_wp;
  logic [AF_DEPTH_LOG2-1:0] r_rp;
  logic [CNT_W-1:0]         r_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_drained;
  logic [SW-1:0]     w_s;
  logic [SW-1:0]     w_s1;
  logic [SW-1:0]     w_tsh;
  logic [N_LOG2-1:0] w_k;
  logic [N_LOG2-1:0] w_span;
  logic [N_LOG2-1:0] w_lo;
  logic [N_LOG2-1:0] w_a;
  logic [N_LOG2-1:0] w_b;
  logic [K_W-1:0]    w_tw;

  // Butterfly address and twiddle index for the current (stage, k).
  always_comb begin
    w_s    = SW'(r_stage);
    w_s1   = w_s + SW'(1);
    w_tsh  = SW'(N_LOG2 - 1) - w_s;
    w_k    = N_LOG2'(r_k);
    w_span = N_LOG2'(1) << w_s;
    w_lo   = w_k & (w_span - N_LOG2'(1));
    w_a    = ((w_k >> w_s) << w_s1) | w_lo;
    w_b    = w_a + w_span;
    w_tw   = K_W'(w_lo << w_tsh);
  end

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(AF_D));
  assign w_push    = (r_state == RD_B);
  assign w_pop     = bus.bf_valid && !w_empty;
  // The last outstanding result is being written back this cycle, so the stage may advance.
  assign w_drained = w_empty || ((r_cnt == CNT_W'(1)) && w_pop);

  // The write-back is combinational from the FIFO head. Addresses read 0 while nothing is in flight.
  assign bus.wr_en     = w_pop;
  assign bus.wr_addr_a = w_empty ? '0 : r_fa[r_rp];
  assign bus.wr_addr_b = w_empty ? '0 : r_fb[r_rp];

  // FIFO storage: the {a, b} pair is captured on the 'b' read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wp] <= w_a;
      r_fb[r_wp] <= w_b;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AF_DEPTH_LOG2'(1);
      if (w_pop)  r_rp <= r_rp + AF_DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Stage/butterfly sequencer with registered read, twiddle and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stage    <= '0;
      r_k        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_addr  <= '0;
      r_tw_en    <= 1'b0;
      r_tw_addr  <= '0;
    end else begin
      r_rd_en    <= 1'b0;
      r_rd_first <= 1'b0;
      r_tw_en    <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= RD_A;
            r_busy  <= 1'b1;
            r_stage <= '0;
            r_k     <= '0;
          end
        end
        RD_A: begin
          if (!bus.stall && !w_full) begin
            r_rd_en    <= 1'b1;
            r_rd_first <= 1'b1;
            r_rd_addr  <= w_a;
            r_state    <= RD_B;
          end
        end
        RD_B: begin
          r_rd_en   <= 1'b1;
          r_rd_addr <= w_b;
          r_tw_en   <= 1'b1;
          r_tw_addr <= w_tw;
          if (r_k == K_LAST) begin
            r_state <= DRAIN;
          end else begin
            r_k     <= r_k + K_W'(1);
            r_state <= RD_A;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            if (r_stage == S_LAST) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= FIN;
            end else begin
              r_stage <= r_stage + STG_W'(1);
              r_k     <= '0;
              r_state <= RD_A;
            end
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.stage    = r_stage;
  assign bus.rd_en    = r_rd_en;
  assign bus.rd_first = r_rd_first;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.tw_en    = r_tw_en;
  assign bus.tw_addr  = r_tw_addr;

`ifdef FFT_SCHED_ERRCHK_EN
  logic r_err;

  // Sticky protocol error: orphan result, result while idle, or start while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((bus.bf_valid && w_empty) ||
                 (bus.bf_valid && (r_state == IDLE)) ||
                 (bus.start && r_busy)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule
